// File: rtl/mem_access_unit.sv
// Memory access unit: takes one decoded load/store from EX, checks alignment,
// runs it over the req/addr_ok/data_ok SRAM bus and returns shaped load data to WB.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsign,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_ale,
    output logic [ADDR_W-1:0] out_badv
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            default: misaligned = (off != 2'd0);
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    store_strb = 4'b0001 << off;
            2'd1:    store_strb = off[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size, input logic [DATA_W-1:0] wd);
        case (size)
            2'd0:    store_data = {4{wd[7:0]}};
            2'd1:    store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_shape(input logic [DATA_W-1:0] rdata, input logic [1:0] off,
                                                     input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    load_shape = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    load_shape = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_shape = rdata;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                is_load_q, is_load_d;
    logic                wr_q, wr_d;
    logic                unsign_q, unsign_d;
    logic [4:0]          rd_q, rd_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_q, req_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_we_q, out_we_d;
    logic                out_ale_q, out_ale_d;
    logic [ADDR_W-1:0]   out_badv_q, out_badv_d;

    // Next-state and capture logic; status outputs are derived from the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        is_load_d  = is_load_q;
        wr_d       = wr_q;
        unsign_d   = unsign_q;
        rd_d       = rd_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        out_data_d = out_data_q;
        out_we_d   = out_we_q;
        out_ale_d  = out_ale_q;
        out_badv_d = out_badv_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush && (in_is_load || in_is_store)) begin
                    addr_d    = in_addr;
                    size_d    = in_size;
                    is_load_d = in_is_load;
                    wr_d      = !in_is_load;
                    unsign_d  = in_unsign;
                    rd_d      = in_rd;
                    wstrb_d   = in_is_load ? 4'b0000 : store_strb(in_size, in_addr[1:0]);
                    wdata_d   = store_data(in_size, in_wdata);
                    if (misaligned(in_size, in_addr[1:0])) begin
                        state_d    = S_DONE;
                        out_ale_d  = 1'b1;
                        out_badv_d = in_addr;
                        out_we_d   = 1'b0;
                        out_data_d = '0;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // Once addr_ok is seen a response is owed, so a flush must drain it.
                if (data_sram_addr_ok) begin
                    state_d = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    state_d    = flush ? S_IDLE : S_DONE;
                    out_data_d = is_load_q ? load_shape(data_sram_rdata, addr_q[1:0], size_q, unsign_q) : '0;
                    out_we_d   = is_load_q;
                    out_ale_d  = 1'b0;
                    out_badv_d = '0;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (data_sram_data_ok) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d != S_DONE) begin
            out_data_d = '0;
            out_we_d   = 1'b0;
            out_ale_d  = 1'b0;
            out_badv_d = '0;
        end else begin
            out_we_d = out_we_d;
        end
        req_d       = (state_d == S_REQ);
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= 2'd0;
            is_load_q   <= 1'b0;
            wr_q        <= 1'b0;
            unsign_q    <= 1'b0;
            rd_q        <= 5'd0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= '0;
            req_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_we_q    <= 1'b0;
            out_ale_q   <= 1'b0;
            out_badv_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            is_load_q   <= is_load_d;
            wr_q        <= wr_d;
            unsign_q    <= unsign_d;
            rd_q        <= rd_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_we_q    <= out_we_d;
            out_ale_q   <= out_ale_d;
            out_badv_q  <= out_badv_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign data_sram_req   = req_q;
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_wdata = wdata_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_rd          = rd_q;
    assign out_we          = out_we_q;
    assign out_ale         = out_ale_q;
    assign out_badv        = out_badv_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan steps plus randomized ops
// compared against an arithmetic reference model of load/store shaping.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_is_load, in_is_store, in_unsign, flush;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        req, wr, addr_ok, data_ok;
    logic [1:0]  bsize;
    logic [31:0] baddr, bwdata, rdata;
    logic [3:0]  wstrb;
    logic        out_valid, out_ready, out_we, out_ale;
    logic [31:0] out_data, out_badv;
    logic [4:0]  out_rd;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsign(in_unsign), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .flush(flush),
        .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(bsize), .data_sram_addr(baddr),
        .data_sram_wstrb(wstrb), .data_sram_wdata(bwdata), .data_sram_addr_ok(addr_ok),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_we(out_we), .out_ale(out_ale), .out_badv(out_badv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Reference load result: pick the addressed bytes arithmetically, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a, input int nb, input bit uns);
        longint v;
        longint span;
        if (nb == 4) return rd;
        span = longint'(1) << (8 * nb);
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int nb);
        if (nb == 1) return (wd % 256) * 32'h0101_0101;
        if (nb == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input int nb);
        int s;
        s = ((1 << nb) - 1) << (a % 4);
        return s[3:0];
    endfunction

    task automatic drive_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdd);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_size = sz;
        in_unsign = uns; in_addr = a; in_wdata = wd; in_rd = rdd;
    endtask

    task automatic release_op();
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    // One complete transaction with a scripted bus slave and WB backpressure.
    task automatic run_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdd,
                          input logic [31:0] rdat, input int aw, input int dw, input int rw);
        int nb;
        bit mis;
        logic [31:0] exp_data;
        nb  = nbytes(sz);
        mis = (a % nb) != 0;
        check("idle_ready", in_ready, 32'd1);
        drive_op(ld, st, sz, uns, a, wd, rdd);
        @(posedge clk);
        @(negedge clk);
        release_op();
        if (!ld && !st) begin
            check("drop_ready", in_ready, 32'd1);
            check("drop_req", req, 32'd0);
            check("drop_valid", out_valid, 32'd0);
            return;
        end
        if (mis) begin
            check("ale_noreq", req, 32'd0);
        end else begin
            for (int i = 0; i < aw; i++) begin
                check("req_hold", req, 32'd1);
                check("addr_hold", baddr, a & ~32'd3);
                @(negedge clk);
            end
            check("req", req, 32'd1);
            check("bus_addr", baddr, a & ~32'd3);
            check("bus_size", bsize, 32'(sz));
            check("bus_wr", wr, 32'(!ld));
            check("bus_wstrb", wstrb, ld ? 32'd0 : 32'(model_strb(a, nb)));
            if (!ld) check("bus_wdata", bwdata, model_wdata(wd, nb));
            addr_ok = 1'b1;
            @(negedge clk);
            addr_ok = 1'b0;
            check("wait_noreq", req, 32'd0);
            check("wait_novalid", out_valid, 32'd0);
            for (int i = 0; i < dw; i++) begin
                @(negedge clk);
                check("wait_novalid", out_valid, 32'd0);
            end
            data_ok = 1'b1; rdata = rdat;
            @(negedge clk);
            data_ok = 1'b0; rdata = $urandom;
        end
        exp_data = (ld && !mis) ? model_load(rdat, a, nb, uns) : 32'd0;
        check("out_valid", out_valid, 32'd1);
        check("out_ale", out_ale, 32'(mis));
        check("out_badv", out_badv, mis ? a : 32'd0);
        check("out_we", out_we, 32'(ld && !mis));
        check("out_data", out_data, exp_data);
        check("out_rd", out_rd, 32'(rdd));
        for (int i = 0; i < rw; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 32'd1);
            check("hold_data", out_data, exp_data);
            if (mis) check("ale_noreq", req, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", out_valid, 32'd0);
        check("retire_ready", in_ready, 32'd1);
        check("retire_req", req, 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0; out_ready = 1'b0;
        in_size = 2'd0; in_unsign = 1'b0; in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
        release_op();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_req", req, 32'd0);
        check("rst_valid", out_valid, 32'd0);
        check("rst_addr", baddr, 32'd0);
        check("rst_wstrb", wstrb, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_badv", out_badv, 32'd0);

        // Test-plan directed steps.
        run_op(1, 0, 2'd0, 0, 32'h0000_1003, 32'd0, 5'd3, 32'h80FF_0000, 0, 0, 0);
        run_op(1, 0, 2'd1, 1, 32'h0000_2002, 32'd0, 5'd4, 32'hBEEF_1234, 0, 0, 0);
        run_op(1, 0, 2'd1, 0, 32'h0000_2002, 32'd0, 5'd5, 32'hBEEF_1234, 0, 0, 0);
        run_op(0, 1, 2'd0, 0, 32'h0000_0010, 32'h0000_00A5, 5'd0, 32'd0, 0, 0, 0);
        run_op(0, 1, 2'd1, 0, 32'h0000_0012, 32'h0000_1234, 5'd0, 32'd0, 0, 0, 0);
        run_op(1, 0, 2'd2, 0, 32'h0000_3001, 32'd0, 5'd7, 32'd0, 0, 0, 2);
        run_op(1, 0, 2'd2, 0, 32'h0000_4000, 32'd0, 5'd8, 32'hCAFE_F00D, 4, 1, 3);
        check("plan_ldb", model_load(32'h80FF_0000, 32'h1003, 1, 0), 32'hFFFF_FF80);

        // Flush in REQ before addr_ok withdraws the request.
        drive_op(1, 0, 2'd2, 0, 32'h0000_5000, 32'd0, 5'd9);
        @(posedge clk);
        @(negedge clk);
        release_op();
        check("freq_req", req, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("freq_withdraw", req, 32'd0);
        check("freq_ready", in_ready, 32'd1);
        check("freq_valid", out_valid, 32'd0);

        // Flush together with in_valid in IDLE: not accepted.
        drive_op(1, 0, 2'd2, 0, 32'h0000_6000, 32'd0, 5'd9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        release_op();
        check("fidle_req", req, 32'd0);
        check("fidle_ready", in_ready, 32'd1);

        // Flush in WAIT: drain the late data_ok, then a normal op.
        drive_op(1, 0, 2'd2, 0, 32'h0000_7000, 32'd0, 5'd10);
        @(posedge clk);
        @(negedge clk);
        release_op();
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_ready", in_ready, 32'd0);
        check("drain_valid", out_valid, 32'd0);
        @(negedge clk);
        check("drain_ready2", in_ready, 32'd0);
        data_ok = 1'b1; rdata = 32'h1111_2222;
        @(negedge clk);
        data_ok = 1'b0;
        check("drain_done_ready", in_ready, 32'd1);
        check("drain_done_valid", out_valid, 32'd0);
        run_op(1, 0, 2'd0, 1, 32'h0000_7001, 32'd0, 5'd11, 32'h0000_9C00, 0, 0, 0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            bit ld, st, uns;
            logic [1:0]  sz;
            logic [31:0] a;
            ld  = 1'($urandom);
            st  = 1'($urandom);
            uns = 1'($urandom);
            sz  = 2'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
            run_op(ld, st, sz, uns, a, $urandom, 5'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
